// File: rtl/switch_matrix_pkg.sv
// Shared constants, FSM state type and width helpers for the switch matrix.
package switch_matrix_pkg;

   localparam logic [2:0] SIDE_OFF    = 3'd0;
   localparam logic [2:0] SIDE_TOP    = 3'd1;
   localparam logic [2:0] SIDE_RIGHT  = 3'd2;
   localparam logic [2:0] SIDE_BOTTOM = 3'd3;
   localparam logic [2:0] SIDE_LEFT   = 3'd4;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} cfg_state_t;

   function automatic int calc_selw(input int nh, input int nv);
      return $clog2((nh > nv) ? nh : nv);
   endfunction

   function automatic int calc_cw(input int nh, input int nv);
      return calc_selw(nh, nv) + 3;
   endfunction

endpackage

// File: rtl/sm_port_mux.sv
// Decodes one port's config word into a routed value and drive enable.
module sm_port_mux
   import switch_matrix_pkg::*;
#(
   parameter int NH   = 5,
   parameter int NV   = 4,
   parameter int SELW = 3,
   parameter int CW   = 6,
   parameter int PORT = 0
) (
   input  logic [CW-1:0] word,
   input  logic [NH-1:0] top_in,
   input  logic [NV-1:0] right_in,
   input  logic [NH-1:0] bottom_in,
   input  logic [NV-1:0] left_in,
   output logic          out,
   output logic          oe
);

   // This port's own side/index, used to reject a self-selection.
   localparam int SELF_SIDE = (PORT < NH) ? 1 : (PORT < NH+NV) ? 2 : (PORT < 2*NH+NV) ? 3 : 4;
   localparam int SELF_IDX  = (PORT < NH) ? PORT : (PORT < NH+NV) ? PORT-NH :
                              (PORT < 2*NH+NV) ? PORT-NH-NV : PORT-2*NH-NV;
   localparam int PW = 1 << SELW;

   logic [2:0]      code;
   logic [SELW-1:0] idx;
   logic [PW-1:0]   src;
   logic            in_range;
   logic            self_sel;

   always_comb begin
      code     = word[2:0];
      idx      = word[CW-1:3];
      src      = '0;
      in_range = 1'b0;
      case (code)
         SIDE_TOP:    begin src[NH-1:0] = top_in;    in_range = int'(idx) < NH; end
         SIDE_RIGHT:  begin src[NV-1:0] = right_in;  in_range = int'(idx) < NV; end
         SIDE_BOTTOM: begin src[NH-1:0] = bottom_in; in_range = int'(idx) < NH; end
         SIDE_LEFT:   begin src[NV-1:0] = left_in;   in_range = int'(idx) < NV; end
         default:     in_range = 1'b0;
      endcase
      self_sel = (int'(code) == SELF_SIDE) && (int'(idx) == SELF_IDX);
      oe       = in_range && !self_sel;
      out      = oe && src[idx];
   end

endmodule

// File: rtl/switch_matrix_cfg.sv
// Serially configured crossbar: each edge port routes from any other pad input.
module switch_matrix_cfg
   import switch_matrix_pkg::*;
#(
   parameter int NH      = 5,
   parameter int NV      = 4,
   parameter int REG_OUT = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [NH-1:0] top_in,
   input  logic [NH-1:0] bottom_in,
   input  logic [NV-1:0] left_in,
   input  logic [NV-1:0] right_in,
   output logic [NH-1:0] top_out,
   output logic [NH-1:0] bottom_out,
   output logic [NV-1:0] left_out,
   output logic [NV-1:0] right_out,
   output logic [NH-1:0] top_oe,
   output logic [NH-1:0] bottom_oe,
   output logic [NV-1:0] left_oe,
   output logic [NV-1:0] right_oe,
   input  logic          cfg_start,
   input  logic          cfg_valid,
   input  logic          cfg_bit,
   input  logic          cfg_abort,
   output logic          cfg_busy,
   output logic          cfg_done
);

   localparam int SELW = calc_selw(NH, NV);
   localparam int CW   = calc_cw(NH, NV);
   localparam int NP   = 2*NH + 2*NV;
   localparam int L    = NP * CW;
   localparam int CNTW = $clog2(L + 1);

   cfg_state_t      state, state_nxt;
   logic [CNTW-1:0] cnt;
   logic [L-1:0]    shadow;
   logic [L-1:0]    active;
   logic            last_bit;
   logic [NP-1:0]   mux_out, mux_oe;
   logic [NP-1:0]   pin_out, pin_oe;

   assign last_bit = cfg_valid && (cnt == CNTW'(L-1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_start) state_nxt = SHIFT;
         SHIFT:   if (cfg_abort) state_nxt = IDLE;
                  else if (last_bit) state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Shadow fills during SHIFT; active only moves on COMMIT so routing never glitches mid-load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         shadow <= '0;
         active <= '0;
      end else begin
         case (state)
            IDLE:   if (cfg_start) cnt <= '0;
            SHIFT:  if (!cfg_abort && cfg_valid) begin
                       shadow <= {shadow[L-2:0], cfg_bit};
                       cnt    <= cnt + 1'b1;
                    end
            COMMIT: active <= shadow;
            default: ;
         endcase
      end
   end

   assign cfg_busy = (state != IDLE);
   assign cfg_done = (state == COMMIT);

   for (genvar p = 0; p < NP; p++) begin : g_port
      sm_port_mux #(.NH(NH), .NV(NV), .SELW(SELW), .CW(CW), .PORT(p)) u_mux (
         .word      (active[p*CW +: CW]),
         .top_in    (top_in),
         .right_in  (right_in),
         .bottom_in (bottom_in),
         .left_in   (left_in),
         .out       (mux_out[p]),
         .oe        (mux_oe[p])
      );
   end

   if (REG_OUT != 0) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            pin_out <= '0;
            pin_oe  <= '0;
         end else begin
            pin_out <= mux_out;
            pin_oe  <= mux_oe;
         end
      end
   end else begin : g_comb
      assign pin_out = mux_out;
      assign pin_oe  = mux_oe;
   end

   assign top_out    = pin_out[NH-1:0];
   assign right_out  = pin_out[NH +: NV];
   assign bottom_out = pin_out[NH+NV +: NH];
   assign left_out   = pin_out[2*NH+NV +: NV];
   assign top_oe     = pin_oe[NH-1:0];
   assign right_oe   = pin_oe[NH +: NV];
   assign bottom_oe  = pin_oe[NH+NV +: NH];
   assign left_oe    = pin_oe[2*NH+NV +: NV];

endmodule

// File: tb/tb_switch_matrix_cfg.sv
// Randomized bench for switch_matrix_cfg against a port-table reference model.
module tb_switch_matrix_cfg;

   localparam int NH = 5, NV = 4, SELW = 3, CW = 6, NP = 18, L = 108;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [NH-1:0] top_in = '0, bottom_in = '0;
   logic [NV-1:0] left_in = '0, right_in = '0;
   logic cfg_start = 0, cfg_valid = 0, cfg_bit = 0, cfg_abort = 0;

   logic [NH-1:0] top_out, bottom_out, top_oe, bottom_oe;
   logic [NV-1:0] left_out, right_out, left_oe, right_oe;
   logic cfg_busy, cfg_done;
   logic [NH-1:0] r_top_out, r_bottom_out, r_top_oe, r_bottom_oe;
   logic [NV-1:0] r_left_out, r_right_out, r_left_oe, r_right_oe;
   logic r_busy, r_done;

   switch_matrix_cfg #(.NH(NH), .NV(NV), .REG_OUT(0)) dut (
      .clk(clk), .rst_n(rst_n),
      .top_in(top_in), .bottom_in(bottom_in), .left_in(left_in), .right_in(right_in),
      .top_out(top_out), .bottom_out(bottom_out), .left_out(left_out), .right_out(right_out),
      .top_oe(top_oe), .bottom_oe(bottom_oe), .left_oe(left_oe), .right_oe(right_oe),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_abort(cfg_abort),
      .cfg_busy(cfg_busy), .cfg_done(cfg_done));

   switch_matrix_cfg #(.NH(NH), .NV(NV), .REG_OUT(1)) dut_r (
      .clk(clk), .rst_n(rst_n),
      .top_in(top_in), .bottom_in(bottom_in), .left_in(left_in), .right_in(right_in),
      .top_out(r_top_out), .bottom_out(r_bottom_out), .left_out(r_left_out), .right_out(r_right_out),
      .top_oe(r_top_oe), .bottom_oe(r_bottom_oe), .left_oe(r_left_oe), .right_oe(r_right_oe),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit), .cfg_abort(cfg_abort),
      .cfg_busy(r_busy), .cfg_done(r_done));

   wire [NP-1:0] all_out   = {left_out, bottom_out, right_out, top_out};
   wire [NP-1:0] all_oe    = {left_oe, bottom_oe, right_oe, top_oe};
   wire [NP-1:0] r_all_out = {r_left_out, r_bottom_out, r_right_out, r_top_out};
   wire [NP-1:0] r_all_oe  = {r_left_oe, r_bottom_oe, r_right_oe, r_top_oe};

   int errors = 0;
   int checks = 0;
   logic [CW-1:0] m_act [NP];
   logic [CW-1:0] m_new [NP];

   // Reference: a port is driven when it names an existing pad other than itself.
   function automatic logic [2*NP-1:0] model();
      logic [NP-1:0] e, o, ins;
      int code, idx, width, base;
      e = '0; o = '0;
      ins = {left_in, bottom_in, right_in, top_in};
      for (int p = 0; p < NP; p++) begin
         code = int'(m_act[p][2:0]);
         idx  = int'(m_act[p][CW-1:3]);
         case (code)
            1: begin width = NH; base = 0;       end
            2: begin width = NV; base = NH;      end
            3: begin width = NH; base = NH+NV;   end
            4: begin width = NV; base = 2*NH+NV; end
            default: begin width = 0; base = 0; end
         endcase
         if (idx < width && base + idx != p) begin
            e[p] = 1'b1;
            o[p] = ins[base+idx];
         end
      end
      return {e, o};
   endfunction

   function automatic logic [L-1:0] pack_new();
      logic [L-1:0] img;
      for (int p = 0; p < NP; p++) img[p*CW +: CW] = m_new[p];
      return img;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic rand_ins();
      top_in = NH'($urandom); bottom_in = NH'($urandom);
      left_in = NV'($urandom); right_in = NV'($urandom);
   endtask

   task automatic rand_cfg();
      for (int p = 0; p < NP; p++) m_new[p] = CW'($urandom);
   endtask

   task automatic clear_new();
      for (int p = 0; p < NP; p++) m_new[p] = '0;
   endtask

   // done_at = cycles after the edge taking the last bit until cfg_done (0 = that cycle)
   task automatic do_load(input logic [L-1:0] img, input int gap_at, input int gap_len,
                          input int abort_at, output int done_at, output bit early);
      done_at = -1; early = 0;
      cfg_start = 1; step(); cfg_start = 0;
      for (int i = 0; i < L; i++) begin
         if (i == gap_at) begin
            for (int g = 0; g < gap_len; g++) begin
               cfg_valid = 0; cfg_start = 1; cfg_bit = 1;
               step();
               if (cfg_done) early = 1;
            end
            cfg_start = 0;
         end
         cfg_valid = 1; cfg_bit = img[L-1-i]; cfg_abort = (i == abort_at);
         step();
         if (i == abort_at) begin
            cfg_valid = 0; cfg_abort = 0;
            return;
         end
         if (cfg_done && i < L-1) early = 1;
      end
      cfg_valid = 0;
      for (int k = 0; k < 4 && done_at < 0; k++) begin
         if (cfg_done) done_at = k;
         else step();
      end
      step();
   endtask

   task automatic check_routes(input string name, input int n);
      logic [2*NP-1:0] exp;
      for (int k = 0; k < n; k++) begin
         rand_ins(); #1;
         exp = model();
         checks++;
         if ({all_oe, all_out} !== exp) begin
            errors++;
            $display("FAIL %s oe/out got=%h exp=%h", name, {all_oe, all_out}, exp);
         end
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 6; k++) begin
         rand_ins(); cfg_valid = 1'($urandom); cfg_bit = 1'($urandom); #3;
         checks++;
         if ({all_oe, all_out, cfg_busy, cfg_done, r_all_oe, r_all_out, r_busy, r_done} !== '0) begin
            errors++;
            $display("FAIL reset_hold got oe=%h out=%h busy=%b done=%b roe=%h rout=%h",
                     all_oe, all_out, cfg_busy, cfg_done, r_all_oe, r_all_out);
         end
      end
      cfg_valid = 0;
      step(); rst_n = 1; step();
      for (int k = 0; k < 4; k++) begin
         rand_ins(); step();
         checks++;
         if ({all_oe, all_out, cfg_busy, r_all_oe, r_all_out} !== '0) begin
            errors++;
            $display("FAIL reset_release got oe=%h out=%h busy=%b", all_oe, all_out, cfg_busy);
         end
      end
   endtask

   task automatic test_single_route();
      int d; bit e;
      clear_new();
      m_new[NH+NV+2] = {3'd1, 3'd1};
      do_load(pack_new(), -1, 0, -1, d, e);
      checks++;
      if (d != 0 || e) begin
         errors++; $display("FAIL single_done_timing got lat=%0d early=%0d exp lat=0 early=0", d, e);
      end
      m_act = m_new;
      for (int k = 0; k < 6; k++) begin
         rand_ins(); #1;
         checks++;
         if (bottom_oe[2] !== 1'b1 || bottom_out[2] !== top_in[1] || (all_oe & ~(NP'(1) << (NH+NV+2))) !== '0) begin
            errors++;
            $display("FAIL single_route got oe=%h bout2=%b exp bout2=%b", all_oe, bottom_out[2], top_in[1]);
         end
      end
   endtask

   task automatic test_self_oob();
      int d; bit e;
      clear_new();
      m_new[0]          = {3'd0, 3'd1};
      m_new[2*NH+NV+3]  = {3'd5, 3'd2};
      m_new[NH]         = {3'd3, 3'd1};
      do_load(pack_new(), -1, 0, -1, d, e);
      m_act = m_new;
      rand_ins(); #1;
      checks++;
      if (top_oe[0] !== 1'b0 || left_oe[3] !== 1'b0 || right_oe[0] !== 1'b1 || right_out[0] !== top_in[3]) begin
         errors++;
         $display("FAIL self_oob got top_oe0=%b left_oe3=%b right_oe0=%b exp 0 0 1", top_oe[0], left_oe[3], right_oe[0]);
      end
      check_routes("self_oob_model", 3);
   endtask

   task automatic test_random_cfg();
      int d; bit e;
      for (int r = 0; r < 4; r++) begin
         // stray valid bits while idle must not be consumed
         for (int k = 0; k < 5; k++) begin
            cfg_valid = 1; cfg_bit = 1'($urandom); step();
         end
         rand_cfg();
         do_load(pack_new(), -1, 0, -1, d, e);
         checks++;
         if (d != 0 || e) begin
            errors++; $display("FAIL random_done_timing got lat=%0d early=%0d exp lat=0 early=0", d, e);
         end
         m_act = m_new;
         check_routes("random_cfg", 4);
      end
   endtask

   task automatic test_abort();
      int d; bit e;
      rand_cfg();
      do_load(pack_new(), -1, 0, 50, d, e);
      checks++;
      if (cfg_busy !== 1'b0) begin
         errors++; $display("FAIL abort_busy got=%b exp=0", cfg_busy);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (cfg_done !== 1'b0) begin
            errors++; $display("FAIL abort_no_done got=%b exp=0", cfg_done);
         end
         step();
      end
      check_routes("abort_unchanged", 4);
   endtask

   task automatic test_gap();
      int d; bit e;
      rand_cfg();
      do_load(pack_new(), 40, 7, -1, d, e);
      checks++;
      if (d != 0 || e) begin
         errors++; $display("FAIL gap_done_timing got lat=%0d early=%0d exp lat=0 early=0", d, e);
      end
      m_act = m_new;
      check_routes("gap_cfg", 4);
   endtask

   task automatic test_reset_mid();
      int d; bit e;
      logic [L-1:0] img;
      rand_cfg(); img = pack_new();
      cfg_start = 1; step(); cfg_start = 0;
      for (int i = 0; i < 30; i++) begin
         cfg_valid = 1; cfg_bit = img[L-1-i]; step();
      end
      cfg_valid = 0;
      #2 rst_n = 0; #1;
      checks++;
      if ({all_oe, all_out, cfg_busy, cfg_done, r_all_oe, r_all_out} !== '0) begin
         errors++; $display("FAIL reset_mid got oe=%h out=%h busy=%b", all_oe, all_out, cfg_busy);
      end
      for (int p = 0; p < NP; p++) m_act[p] = '0;
      step(); rst_n = 1; step();
      check_routes("reset_mid_off", 2);
      rand_cfg();
      do_load(pack_new(), -1, 0, -1, d, e);
      checks++;
      if (d != 0 || e) begin
         errors++; $display("FAIL reload_done_timing got lat=%0d early=%0d exp lat=0 early=0", d, e);
      end
      m_act = m_new;
      check_routes("reload", 4);
   endtask

   task automatic test_reg_out();
      logic [2*NP-1:0] exp_cur;
      clear_new();
      for (int p = 0; p < NP; p++) m_new[p] = {3'(p % 5), 3'd1};
      rand_cfg();
      begin
         int d; bit e;
         do_load(pack_new(), -1, 0, -1, d, e);
      end
      m_act = m_new;
      step();
      for (int k = 0; k < 8; k++) begin
         rand_ins(); #1;
         exp_cur = model();
         checks++;
         if ({all_oe, all_out} !== exp_cur) begin
            errors++; $display("FAIL regout_comb got=%h exp=%h", {all_oe, all_out}, exp_cur);
         end
         step();
         checks++;
         if ({r_all_oe, r_all_out} !== exp_cur) begin
            errors++; $display("FAIL regout_lag got=%h exp=%h", {r_all_oe, r_all_out}, exp_cur);
         end
      end
   endtask

   initial begin
      for (int p = 0; p < NP; p++) m_act[p] = '0;
      test_reset();
      test_single_route();
      test_self_oob();
      test_random_cfg();
      test_abort();
      test_gap();
      test_reset_mid();
      test_reg_out();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
